// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out on dout.
// Define BIT_SERIALIZER_LSB_FIRST_EN to shift words LSB first; the default build shifts MSB first.
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Handshake: a word transfers on a rising edge where in_valid and in_ready are both 1;
    // the source holds in_data steady until that edge, and in_ready never depends on in_valid.

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             accept;
    logic             load;
    logic             cur_bit;

    assign accept   = in_valid && !hold_full;
    assign cnt_zero = (cnt == '0);
    // Load from IDLE, or reload on the last bit so consecutive words stream without a gap.
    assign load     = hold_full && ((state == IDLE) || cnt_zero);
    assign in_ready = !hold_full;

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    assign cur_bit       = shreg[0];
    assign shreg_shifted = shreg >> 1;
`else
    assign cur_bit       = shreg[WIDTH-1];
    assign shreg_shifted = shreg << 1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_zero && !hold_full) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                hold_data <= in_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                shreg <= hold_data;
                cnt   <= CW'(WIDTH - 1);
            end else if ((state == SHIFT) && !cnt_zero) begin
                shreg <= shreg_shifted;
                cnt   <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        dout_valid = (state == SHIFT);
        dout       = dout_valid && cur_bit;
        dout_last  = dout_valid && cnt_zero;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: randomized driver, bit-level reference queue, negedge monitor.
`timescale 1ns/1ps
module tb_bit_serializer;

    localparam int WIDTH = 8;

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    localparam logic [WIDTH-1:0] FIRST_WORD = 8'h0B;
    localparam logic [23:0] STREAM_BITS = 24'h2DB6FF;
`else
    localparam logic [WIDTH-1:0] FIRST_WORD = 8'hD0;
    localparam logic [23:0] STREAM_BITS = 24'hB46DFF;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             dout_last;

    logic [1:0] exp_q[$];
    logic       seen_q[$];
    int n_checks  = 0;
    int n_fail    = 0;
    int accepts   = 0;
    int bp_cycles = 0;
    int bits_seen = 0;
    int run_len   = 0;
    int last_run  = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a word becomes WIDTH bits in wire order, the final one flagged as last.
    task automatic model_push(input logic [WIDTH-1:0] d);
        logic b;
        for (int i = 0; i < WIDTH; i++) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
            b = d[i];
`else
            b = d[WIDTH-1-i];
`endif
            exp_q.push_back({b, (i == WIDTH - 1)});
        end
    endtask

    // Offers a word; with scramble set, in_data changes every stalled cycle and whatever
    // value is present on the handshake edge is the one expected on dout.
    task automatic send_word(input logic [WIDTH-1:0] d, input bit scramble);
        logic [WIDTH-1:0] cur;
        int waited;
        cur = d;
        waited = 0;
        while (waited < 200) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = cur;
            if (in_ready) begin
                model_push(cur);
                accepts++;
                @(posedge clk);
                return;
            end
            waited++;
            bp_cycles++;
            if (scramble) cur = WIDTH'($urandom);
        end
        check("accept_timeout", waited, 0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (((exp_q.size() != 0) || dout_valid) && (n < 1000));
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_idle", dout_valid, 0);
    endtask

    function automatic logic [31:0] pack_seen();
        logic [31:0] v;
        v = '0;
        foreach (seen_q[i]) v = {v[30:0], seen_q[i]};
        return v;
    endfunction

    always @(negedge clk) begin
        logic [1:0] e;
        if (rst) begin
            run_len = 0;
        end else if (dout_valid) begin
            run_len++;
            bits_seen++;
            seen_q.push_back(dout);
            if (exp_q.size() == 0) begin
                check("unexpected_bit_queue_size", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("dout_bit", dout, e[1]);
                check("dout_last", dout_last, e[0]);
            end
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            check("idle_outputs_zero", {dout, dout_last}, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_dout_valid", dout_valid, 0);
        check("reset_dout", dout, 0);
        check("reset_dout_last", dout_last, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single word: two-cycle latency, eight bits, then idle
        seen_q.delete();
        send_word(FIRST_WORD, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("lat_n1_dout_valid", dout_valid, 0);
        check("lat_n1_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        check("lat_n2_dout_valid", dout_valid, 1);
        repeat (8) @(negedge clk);
        #1;
        check("single_done_valid", dout_valid, 0);
        check("single_run_len", last_run, 8);
        check("single_bits", pack_seen(), 32'h0000_00D0);

        // Back-to-back stream of three words
        wait_drain();
        seen_q.delete();
        accepts = 0;
        bp_cycles = 0;
        send_word(8'hB4, 1'b0);
        send_word(8'h6D, 1'b0);
        send_word(8'hFF, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();
        check("stream_run_len", last_run, 24);
        check("stream_accepts", accepts, 3);
        check("stream_backpressure_seen", (bp_cycles != 0), 1);
        check("stream_bits", pack_seen(), {8'h00, STREAM_BITS});

        // Backpressure with in_data changing while stalled
        seen_q.delete();
        base = bits_seen;
        send_word(WIDTH'($urandom), 1'b1);
        send_word(WIDTH'($urandom), 1'b1);
        send_word(WIDTH'($urandom), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();
        check("bp_bit_count", bits_seen - base, 3 * WIDTH);

        // Reset in the middle of a word with a second word held
        send_word(8'hAA, 1'b0);
        send_word(8'h55, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        base = bits_seen;
        n = 0;
        while ((bits_seen < base + 2) && (n < 50)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_reset_reached_bit3", bits_seen - base, 2);
        check("mid_reset_hold_full", in_ready, 0);
        rst = 1'b1;
        #1;
        check("mid_reset_dout_valid", dout_valid, 0);
        check("mid_reset_dout", dout, 0);
        check("mid_reset_in_ready", in_ready, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = bits_seen;
        repeat (20) @(negedge clk);
        #1;
        check("post_reset_no_bits", bits_seen - base, 0);
        check("post_reset_in_ready", in_ready, 1);

        // Random traffic with random gaps and occasional scrambling
        for (int i = 0; i < 40; i++) begin
            send_word(WIDTH'($urandom), ($urandom_range(0, 1) == 1));
            n = $urandom_range(0, 3);
            if (n != 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (n - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
